cpu0_uart_tx_port: RTL
======================

// Module: cpu0_uart_tx_port
// PURPOSE
// Memory-mapped serial console output for the cpu0 system. Shares the cpu0 memory
// bus (mar/mdr/dbus, m_en/m_rw/m_size) with memory0 and claims the 8-byte window at
// IOADDR. Bytes stored by the CPU are queued in a TX FIFO and shifted out 8N1 on tx.
// CPU polls STATUS before each store, so flow control stays with software.
// PARAMETERS
// IOADDR        'h7000  base byte address of the register window (TXDATA=+0, STATUS=+4)
// FIFO_DEPTH    16      TX FIFO entries; power of two, >=2
// CLKS_PER_BIT  16      clock cycles per serial bit; >=2
// PORTS
// clock     in   1   system clock, all state changes on posedge
// reset     in   1   synchronous, active-high reset
// en        in   1   bus access enable (cpu m_en)
// rw        in   1   1=read, 0=write (cpu m_rw)
// m_size    in   2   access size; ignored, only dbus_in[7:0] is used for TXDATA
// abus      in   32  byte address (cpu mar)
// dbus_in   in   32  write data (cpu mdr)
// dbus_out  out  32  read data; 32'hZZZZZZZZ unless a read hits the window
// sel       out  1   comb: en && abus in [IOADDR, IOADDR+7]
// tx        out  1   serial line, idle high
// tx_busy   out  1   1 while a frame is on the line
// BEHAVIOUR
// - Reset (sync): FIFO empty, rd/wr ptrs=0, overflow=0, FSM=IDLE, tx=1, tx_busy=0,
//   bit counter/divider=0, en_q=0. Reset mid-frame abandons the frame, tx=1 next edge.
// - Access strobe: en_q registers en; an access acts once, on the first posedge where
//   en=1 && en_q=0 (cpu holds en for exactly one state; strobe guards longer holds).
// - TXDATA write (abus==IOADDR, rw=0, strobe): if !full push dbus_in[7:0], count+1 at
//   that edge; if full, byte dropped, overflow<=1 (sticky). Reads of TXDATA return 0.
// - STATUS read (abus==IOADDR+4, rw=1): dbus_out comb = {19'b0, count[CW-1:0] at
//   [12:8], 4'b0, overflow[3], busy[2], full[1], empty[0]}; CW=$clog2(FIFO_DEPTH)+1,
//   count field zero-extended into [12:8] (depth<=16 fits). Valid while en=1, so the
//   cpu's memReadEnd one state later samples it.
// - STATUS write with dbus_in[3]=1 (strobe) clears overflow; other bits ignored.
// - Other addresses in window (+1..+3, +5..+7): reads 0, writes ignored.
// - FSM IDLE -> START when !empty: pop head into shift reg, tx=0, busy=1 same edge.
//   START (CLKS_PER_BIT cycles) -> DATA: 8 bits LSB first, CLKS_PER_BIT each ->
//   STOP: tx=1 for CLKS_PER_BIT -> IDLE (busy=0) or directly START if !empty
//   (back-to-back frames, no idle gap). Frame = 10*CLKS_PER_BIT cycles.
// - Simultaneous push and pop same edge: both happen, count unchanged; a push while
//   full is accepted iff a pop occurs that edge (no overflow).
// - Pointers wrap modulo FIFO_DEPTH; full = count==FIFO_DEPTH, empty = count==0.
// - tx registered (glitch-free); tx_busy = (FSM!=IDLE).
// TESTING
// CLKS_PER_BIT=4, FIFO_DEPTH=4 for all directed tests.
// 1 reset held 3 cycles mid-frame -> tx=1, tx_busy=0, STATUS=0x00000001 after release.
// 2 store 0x41 to 0x7000 -> tx 0 | 1,0,0,0,0,0,1,0 | 1, 4 cycles each, busy for 40.
// 3 store 0x55,0xAA quickly -> frames back-to-back, no idle bit between stop and start.
// 4 while first frame active, store 5 more bytes -> 4 queued, 5th dropped, STATUS[3]=1,
//   count=4; store 0x8 to 0x7004 -> overflow=0.
// 5 en held high 3 cycles on one TXDATA write -> exactly one byte pushed.
// 6 read 0x7000/0x6FFC/0x7008 -> 0 / Z / Z; sel=1,0,0.

Source files
------------

// File: rtl/cpu0_uart_tx_port.sv
// cpu0_uart_tx_port
//   Memory-mapped serial console transmitter on the shared cpu0 memory bus.
//   The CPU stores bytes to TXDATA; they queue in a small FIFO and are shifted
//   out 8N1 (LSB first) on tx. Software polls STATUS before each store.
//
//   Register window at IOADDR (8 bytes):
//     +0 TXDATA  write: queue dbus_in[7:0] (dropped and overflow set if full)
//                read : 0
//     +4 STATUS  read : {19'b0, count[12:8], 4'b0, overflow, busy, full, empty}
//                write: dbus_in[3]=1 clears overflow
//     others     read 0, writes ignored
//
// Ports
//   clock     system clock, all state changes on posedge
//   reset     synchronous, active-high
//   en        bus access enable (cpu m_en)
//   rw        1=read, 0=write (cpu m_rw)
//   m_size    access size, not used (only byte lane 0 is taken)
//   abus      byte address (cpu mar)
//   dbus_in   write data (cpu mdr)
//   dbus_out  read data, high-impedance unless a read hits the window
//   sel       combinational window hit: en && abus in [IOADDR, IOADDR+7]
//   tx        serial line, idle high, registered
//   tx_busy   high while a frame is on the line
//
// Bus handshake: a bus access acts exactly once, on the first posedge where
// en is high after having been low (en_q holds last cycle's en). Reads are
// purely combinational and valid for as long as en is held.
module cpu0_uart_tx_port #(
  parameter logic [31:0] IOADDR       = 32'h7000,
  parameter int          FIFO_DEPTH   = 16,
  parameter int          CLKS_PER_BIT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic        rw,
  input  logic [1:0]  m_size,
  input  logic [31:0] abus,
  input  logic [31:0] dbus_in,
  output logic [31:0] dbus_out,
  output logic        sel,
  output logic        tx,
  output logic        tx_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state;
  state_t          next_state;

  logic            en_q;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            overflow;
  logic [DW-1:0]   div;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;

  logic [31:0]     off;
  logic            in_win;
  logic            strobe;
  logic            wr_txdata;
  logic            clr_ovf;
  logic            full;
  logic            empty;
  logic            bit_end;
  logic            pop;
  logic            push;
  logic            ovf_set;
  logic [4:0]      count_field;
  logic [31:0]     status;
  logic            unused_bits;

  // Address decode and access strobe
  assign off       = abus - IOADDR;
  assign in_win    = (abus >= IOADDR) && (off < 32'd8);
  assign sel       = en && in_win;
  assign strobe    = en && !en_q;
  assign wr_txdata = strobe && sel && !rw && (off == 32'd0);
  assign clr_ovf   = strobe && sel && !rw && (off == 32'd4) && dbus_in[3];

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign bit_end = (div == DW'(CLKS_PER_BIT - 1));

  // A store into a full FIFO still lands if the transmitter frees a slot
  // on the same edge.
  assign push    = wr_txdata && (!full || pop);
  assign ovf_set = wr_txdata && full && !pop;

  assign tx_busy     = (state != IDLE);
  assign count_field = 5'(count);
  assign status      = {19'b0, count_field, 4'b0, overflow, tx_busy, full, empty};
  assign dbus_out    = (sel && rw) ? ((off == 32'd4) ? status : 32'h0) : 32'hzzzzzzzz;

  assign unused_bits = ^{m_size, dbus_in[31:8]};

  // Next-state logic; pop marks the edge that loads a new frame
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          next_state = START;
          pop        = 1'b1;
        end
      end
      START: begin
        if (bit_end) next_state = DATA;
      end
      DATA: begin
        if (bit_end && (bit_idx == 3'd7)) next_state = STOP;
      end
      STOP: begin
        if (bit_end) begin
          // Chain straight into the next start bit when data is waiting
          if (!empty) begin
            next_state = START;
            pop        = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      en_q     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      div      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      state <= next_state;
      en_q  <= en;

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (ovf_set)      overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;

      // Bit-period divider free-runs only while a frame is active
      if ((state == IDLE) || bit_end) div <= '0;
      else                            div <= div + DW'(1);

      if (pop) begin
        shreg   <= mem[rd_ptr];
        tx      <= 1'b0;
        bit_idx <= '0;
      end else begin
        case (state)
          IDLE: tx <= 1'b1;
          START: begin
            if (bit_end) begin
              tx    <= shreg[0];
              shreg <= shreg >> 1;
            end
          end
          DATA: begin
            if (bit_end) begin
              if (bit_idx == 3'd7) begin
                tx <= 1'b1;
              end else begin
                tx    <= shreg[0];
                shreg <= shreg >> 1;
              end
              bit_idx <= bit_idx + 3'd1;
            end
          end
          STOP: tx <= 1'b1;
          default: tx <= 1'b1;
        endcase
      end
    end
  end

  // FIFO storage carries no reset; only pointers and count define contents
  always_ff @(posedge clock) begin
    if (push && !reset) mem[wr_ptr] <= dbus_in[7:0];
  end

endmodule
